fp_addsub_unit: RTL
===================

# fp_addsub_unit

Parametrised IEEE-754-style floating-point adder/subtractor: the next generation of the team's multicycle FP add block. It adds configurable exponent/mantissa widths, subnormal operands, round-to-nearest-even, full normalisation after cancellation, special-value handling and status flags. It sits behind the same `start`/`busy`/`ready` handshake as the existing FP datapath blocks, and has fixed latency.

## Interface
- `EXP_W`, default 8: exponent field width (≥3).
- `MAN_W`, default 23: stored fraction width (≥2). Word width `W = 1+EXP_W+MAN_W`; bias `= 2^(EXP_W-1)-1`.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request; sampled only in IDLE and DONE.
- `op`  in  1: 0 = a+b, 1 = a−b. Sampled with `start`.
- `data_a`, `data_b`  in  W: operands {sign, exp, frac}. Sampled with `start`.
- `busy`  out  1: high in UNPACK, ALIGN, ADD, NORM, ROUND.
- `ready`  out  1: high in DONE only.
- `data_o`  out  W: result; forced to 0 when `ready`=0.
- `flags`  out  3: {invalid, overflow, inexact}; forced to 0 when `ready`=0.

## Operation
- FSM states: IDLE → UNPACK → ALIGN → ADD → NORM → ROUND → DONE. Each non-idle state lasts exactly one cycle except DONE.
- IDLE: `start`=1 registers operands and `op`, then goes to UNPACK.
- DONE: holds the result indefinitely. `start`=1 registers new operands and goes directly to UNPACK. DONE never returns to IDLE except by `reset`.
- `start` during busy states is ignored. Operand inputs are not re-sampled.
- UNPACK:
  - Hidden bit = (exp≠0).
  - Effective exponent = max(exp,1), so subnormals are handled.
  - b's sign is inverted when `op`=1.
  - Classify NaN (exp all ones, frac≠0), Inf, zero.
- ALIGN:
  - Swap operands so |A|≥|B| (compare exp, then mantissa).
  - Shift B's mantissa right by the exponent difference, keeping guard, round and sticky bits.
  - Shift amount saturates at MAN_W+3; every shifted-out 1 ORs into sticky.
- ADD:
  - Effective subtract when signs differ.
  - Datapath width `MAN_W+5`: carry, hidden, frac, G, R, S.
  - Result sign = sign of A.
- NORM:
  - On carry out: shift right 1, OR the lost bit into sticky, exp+1.
  - Otherwise: shift left by the leading-zero count, limited so the exponent does not go below 1. If the hidden bit is then still 0, the result is subnormal and exp field = 0.
  - Single-cycle priority encoder.
- ROUND:
  - Round-to-nearest-even on G/R/S.
  - Mantissa overflow from rounding → exp+1.
  - Exp ≥ all-ones → ±Inf with overflow=1 and inexact=1.
  - inexact = G|R|S, or overflow.
- Zero results:
  - Exact zero from effective subtract → +0.
  - (−0)+(−0), or (−0)−(+0) → −0.
- Specials (bypass arithmetic, result valid in DONE with the same latency):
  - Any NaN input → canonical qNaN {0, all ones, 1000…0}, invalid=0.
  - Inf−Inf (effective) → canonical qNaN, invalid=1.
  - Inf±finite → that Inf.
  - Inf+Inf of the same sign → that Inf.
- Reset: state=IDLE; `busy`, `ready`, `data_o`, `flags` = 0; all internal registers cleared.
- Reset asserted in any state, including mid-operation, takes effect at that edge: no output from the aborted operation ever appears.

## Timing
- `start` sampled high at edge k (IDLE or DONE).
- `busy`=1 from after edge k through edge k+5.
- `ready`=1 and `data_o`/`flags` valid after edge k+5.
- Latency is 5 cycles, independent of operands.
- Back-to-back operation: `start` held high in DONE gives one `ready` cycle per 6 clocks.
- `ready` drops the cycle after a restart from DONE. `data_o` returns to 0 at the same time.
- `start` high in the same cycle as `reset`: reset wins, next state is IDLE.

## Test plan
- 0x3F800000 + 0x40000000, op=0 → 0x40400000, flags=000. Check `busy` high exactly 5 cycles and `ready` after edge k+5. Also pulse `start` mid-busy: it is ignored.
- 0x3F800000 − 0x3F800000 → 0x00000000. 0x80000000 + 0x80000000 → 0x80000000. Cancellation: 0x3F800001 − 0x3F800000 → 0x34000000.
- Rounding ties: 0x3F800000 + 0x33800000 → 0x3F800000 (inexact=1). 0x3F800001 + 0x33800000 → 0x3F800002 (inexact=1).
- Overflow and subnormal: 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags=011. 0x00800000 − 0x00400000 → 0x00400000, flags=000.
- Specials: 0x7F800000 − 0x7F800000 → 0x7FC00000, flags=100. 0x7FC00123 + 0x3F800000 → 0x7FC00000. 0xFF800000 + 0x42C80000 → 0xFF800000.
- Reset and restart:
  - Assert `reset` during ALIGN: outputs are 0 next cycle, and no `ready` follows.
  - Parametrised run with EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 → 0x4000.
  - DONE with `start` held: consecutive results every 6 cycles.

Source files
------------

// File: rtl/fp_addsub_unit_if.sv
// fp_addsub_unit_if: handshake and operand/result bus for fp_addsub_unit.
//   master : drives start/op/data_a/data_b, observes busy/ready/data_o/flags
//   slave  : the adder side of the same bundle
//   flags  : {invalid, overflow, inexact}
interface fp_addsub_unit_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic         op;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic         busy;
  logic         ready;
  logic [W-1:0] data_o;
  logic [2:0]   flags;

  modport master (
    output start, op, data_a, data_b,
    input  busy, ready, data_o, flags
  );

  modport slave (
    input  start, op, data_a, data_b,
    output busy, ready, data_o, flags
  );
endinterface

// File: rtl/fp_addsub_unit.sv
// fp_addsub_unit: multicycle IEEE-754-style add/subtract, fixed 5-cycle
// latency, round-to-nearest-even, subnormals, specials and status flags.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - slave side of fp_addsub_unit_if (start/op/data_a/data_b in,
//           busy/ready/data_o/flags out; data_o/flags are 0 unless ready)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start, outputs quiet
// S_UNPACK | split fields, hidden bit, effective sign of b, specials
// S_ALIGN  | order by magnitude, shift smaller operand right with G/R/S
// S_ADD    | effective add or subtract of aligned mantissas
// S_NORM   | carry shift right or leading-zero shift left
// S_ROUND  | round-to-nearest-even, overflow to Inf, pack result
// S_DONE   | result held; start restarts directly into S_UNPACK
module fp_addsub_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic              clock,
  input logic              reset,
  fp_addsub_unit_if.slave  bus
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int XW     = MAN_W + 5;  // carry, hidden, frac, G, R, S
  localparam int SH_MAX = MAN_W + 3;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               op_q, op_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [EXP_W-1:0]   ea_q, ea_d, eb_q, eb_d;
  logic [MAN_W:0]     ma_q, ma_d, mb_q, mb_d;
  logic               spec_q, spec_d, spec_inv_q, spec_inv_d;
  logic [W-1:0]       spec_res_q, spec_res_d;
  logic               sx_q, sx_d, sub_q, sub_d;
  logic [EXP_W:0]     ex_q, ex_d;
  logic [XW-1:0]      mx_q, mx_d, my_q, my_d;
  logic [W-1:0]       res_q, res_d;
  logic [2:0]         flg_q, flg_d;

  // Unpack view of the registered operands.
  logic [EXP_W-1:0] ua_exp, ub_exp;
  logic [MAN_W-1:0] ua_frac, ub_frac;
  logic             ua_nan, ua_inf, ub_nan, ub_inf, ub_sign;

  assign ua_exp  = a_q[W-2:MAN_W];
  assign ub_exp  = b_q[W-2:MAN_W];
  assign ua_frac = a_q[MAN_W-1:0];
  assign ub_frac = b_q[MAN_W-1:0];
  assign ua_nan  = (&ua_exp) && (|ua_frac);
  assign ua_inf  = (&ua_exp) && !(|ua_frac);
  assign ub_nan  = (&ub_exp) && (|ub_frac);
  assign ub_inf  = (&ub_exp) && !(|ub_frac);
  assign ub_sign = b_q[W-1] ^ op_q;

  // Alignment.
  logic             swap, s_big, s_sml;
  logic [EXP_W-1:0] e_big, e_sml, e_diff;
  logic [MAN_W:0]   m_big, m_sml;
  logic [31:0]      sh_amt;
  logic [XW-1:0]    y_ext, y_shr, y_al;
  logic             y_lost;

  assign swap   = (eb_q > ea_q) || ((eb_q == ea_q) && (mb_q > ma_q));
  assign e_big  = swap ? eb_q : ea_q;
  assign e_sml  = swap ? ea_q : eb_q;
  assign m_big  = swap ? mb_q : ma_q;
  assign m_sml  = swap ? ma_q : mb_q;
  assign s_big  = swap ? sb_q : sa_q;
  assign s_sml  = swap ? sa_q : sb_q;
  assign e_diff = e_big - e_sml;
  // Beyond MAN_W+3 the whole smaller operand lands in sticky anyway.
  assign sh_amt = (32'(e_diff) > 32'(SH_MAX)) ? 32'(SH_MAX) : 32'(e_diff);
  assign y_ext  = {1'b0, m_sml, 3'b000};
  assign y_shr  = y_ext >> sh_amt;
  assign y_lost = |(y_ext & ~({XW{1'b1}} << sh_amt));
  assign y_al   = {y_shr[XW-1:1], y_shr[0] | y_lost};

  // Normalisation: leading zeros below the carry bit, clamped so exp >= 1.
  logic [31:0]   lz, norm_max, shl;
  logic [XW-1:0] sum_res;

  assign sum_res = sub_q ? (mx_q - my_q) : (mx_q + my_q);

  always_comb begin
    lz = 32'(XW - 1);
    for (int i = 0; i < XW - 1; i++) begin
      if (mx_q[i]) lz = 32'(XW - 2 - i);
    end
  end

  assign norm_max = 32'(ex_q) - 32'd1;
  assign shl      = (lz < norm_max) ? lz : norm_max;

  // Rounding.
  logic             rnd_inc, rnd_hid, rnd_ovf, rnd_inx;
  logic [MAN_W+1:0] rnd_sum;
  logic [MAN_W-1:0] rnd_frac;
  logic [EXP_W:0]   rnd_exp;

  assign rnd_inc  = mx_q[2] & (mx_q[1] | mx_q[0] | mx_q[3]);
  assign rnd_sum  = {1'b0, mx_q[XW-2:3]} + {{(MAN_W+1){1'b0}}, rnd_inc};
  assign rnd_hid  = rnd_sum[MAN_W+1] | rnd_sum[MAN_W];
  assign rnd_frac = rnd_sum[MAN_W+1] ? rnd_sum[MAN_W:1] : rnd_sum[MAN_W-1:0];
  assign rnd_exp  = ex_q + {{EXP_W{1'b0}}, rnd_sum[MAN_W+1]};
  assign rnd_ovf  = rnd_hid && (rnd_exp >= {1'b0, {EXP_W{1'b1}}});
  assign rnd_inx  = mx_q[2] | mx_q[1] | mx_q[0] | rnd_ovf;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    spec_d     = spec_q;
    spec_inv_d = spec_inv_q;
    spec_res_d = spec_res_q;
    sx_d       = sx_q;
    sub_d      = sub_q;
    ex_d       = ex_q;
    mx_d       = mx_q;
    my_d       = my_q;
    res_d      = res_q;
    flg_d      = flg_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_UNPACK;
          op_d    = bus.op;
          a_d     = bus.data_a;
          b_d     = bus.data_b;
        end
      end
      S_UNPACK: begin
        state_d    = S_ALIGN;
        sa_d       = a_q[W-1];
        sb_d       = ub_sign;
        ea_d       = (|ua_exp) ? ua_exp : EXP_W'(1);
        eb_d       = (|ub_exp) ? ub_exp : EXP_W'(1);
        ma_d       = {|ua_exp, ua_frac};
        mb_d       = {|ub_exp, ub_frac};
        spec_d     = ua_nan | ub_nan | ua_inf | ub_inf;
        spec_inv_d = 1'b0;
        spec_res_d = QNAN;
        if (ua_nan || ub_nan) begin
          spec_res_d = QNAN;
        end else if (ua_inf && ub_inf && (a_q[W-1] != ub_sign)) begin
          spec_res_d = QNAN;
          spec_inv_d = 1'b1;
        end else if (ua_inf) begin
          spec_res_d = {a_q[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (ub_inf) begin
          spec_res_d = {ub_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
      end
      S_ALIGN: begin
        state_d = S_ADD;
        sx_d    = s_big;
        sub_d   = s_big ^ s_sml;
        ex_d    = {1'b0, e_big};
        mx_d    = {1'b0, m_big, 3'b000};
        my_d    = y_al;
      end
      S_ADD: begin
        state_d = S_NORM;
        mx_d    = sum_res;
        // Exact cancellation always yields +0.
        if (sub_q && !(|sum_res)) sx_d = 1'b0;
      end
      S_NORM: begin
        state_d = S_ROUND;
        if (mx_q[XW-1]) begin
          mx_d = {1'b0, mx_q[XW-1:2], mx_q[1] | mx_q[0]};
          ex_d = ex_q + (EXP_W+1)'(1);
        end else begin
          mx_d = mx_q << shl;
          ex_d = ex_q - (EXP_W+1)'(shl);
        end
      end
      S_ROUND: begin
        state_d = S_DONE;
        if (spec_q) begin
          res_d = spec_res_q;
          flg_d = {spec_inv_q, 2'b00};
        end else if (rnd_ovf) begin
          res_d = {sx_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flg_d = 3'b011;
        end else begin
          res_d = {sx_q, (rnd_hid ? rnd_exp[EXP_W-1:0] : {EXP_W{1'b0}}), rnd_frac};
          flg_d = {2'b00, rnd_inx};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      ea_q       <= '0;
      eb_q       <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      spec_q     <= 1'b0;
      spec_inv_q <= 1'b0;
      spec_res_q <= '0;
      sx_q       <= 1'b0;
      sub_q      <= 1'b0;
      ex_q       <= '0;
      mx_q       <= '0;
      my_q       <= '0;
      res_q      <= '0;
      flg_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      spec_q     <= spec_d;
      spec_inv_q <= spec_inv_d;
      spec_res_q <= spec_res_d;
      sx_q       <= sx_d;
      sub_q      <= sub_d;
      ex_q       <= ex_d;
      mx_q       <= mx_d;
      my_q       <= my_d;
      res_q      <= res_d;
      flg_q      <= flg_d;
    end
  end

  assign bus.busy   = (state_q == S_UNPACK) || (state_q == S_ALIGN) || (state_q == S_ADD) ||
                      (state_q == S_NORM) || (state_q == S_ROUND);
  assign bus.ready  = (state_q == S_DONE);
  assign bus.data_o = bus.ready ? res_q : '0;
  assign bus.flags  = bus.ready ? flg_q : 3'b000;
endmodule
